// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32 x WIDTH register file (X31 reads zero) feeding a single
// registered output slot for the ALU. Define OPERAND_FETCH_BYPASS_EN to forward BusW on same-cycle hazards.
module operand_fetch #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic             UseImm,
  input  logic [WIDTH-1:0] Imm,
  input  logic [3:0]       ALUCtrlIn,
  input  logic             RegWr,
  input  logic [4:0]       RW,
  input  logic [WIDTH-1:0] BusW,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [3:0]       ALUCtrl
);

  localparam logic [4:0] ZeroReg = 5'(NREGS - 1);

  logic [WIDTH-1:0] regFile [NREGS-1];
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             accept;

  // NOTE: the register file is reset explicitly because reset must clear all
  // architectural state; this forces flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int i = 0; i < NREGS - 1; i++) regFile[i] <= '0;
    end else if (RegWr && RW != ZeroReg) begin
      regFile[RW] <= BusW;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    opA = '0;
    opB = Imm;
    if (RA != ZeroReg) opA = regFile[RA];
    if (!UseImm) begin
      opB = '0;
      if (RB != ZeroReg) opB = regFile[RB];
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    if (RegWr && RW != ZeroReg) begin
      if (RW == RA) opA = BusW;
      if (!UseImm && RW == RB) opB = BusW;
    end
`endif
  end

  assign InReady = !OutValid || OutReady;
  assign accept  = InValid && InReady;

  // Operands are a snapshot taken at accept; they only move on the next accept.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      OutValid <= 1'b0;
      BusA     <= '0;
      BusB     <= '0;
      ALUCtrl  <= '0;
    end else if (accept) begin
      OutValid <= 1'b1;
      BusA     <= opA;
      BusB     <= opB;
      ALUCtrl  <= ALUCtrlIn;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule
